// File: rtl/dmem_port_arbiter_if.sv
// Bundled request/response and RAM-side signals of the data-memory port arbiter.
// The arbiter takes the slave view; requesters and the RAM together form the master view.
interface dmem_port_arbiter_if #(
  parameter int BIN_DIG = 32,
  parameter int ADDR_W  = 10
);
  logic               lsu_req_valid;
  logic               lsu_req_ready;
  logic               lsu_we;
  logic [1:0]         lsu_size;
  logic               lsu_unsigned;
  logic [BIN_DIG-1:0] lsu_addr;
  logic [BIN_DIG-1:0] lsu_wdata;
  logic               lsu_rsp_valid;
  logic [BIN_DIG-1:0] lsu_rdata;
  logic               lsu_err;

  logic               if_req_valid;
  logic               if_req_ready;
  logic [BIN_DIG-1:0] if_addr;
  logic               if_rsp_valid;
  logic [BIN_DIG-1:0] if_rdata;

  logic               mem_en;
  logic [3:0]         mem_be;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BIN_DIG-1:0] mem_wdata;
  logic [BIN_DIG-1:0] mem_rdata;

  modport slave (
    input  lsu_req_valid, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_err,
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rdata,
    output mem_en, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output lsu_req_valid, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata, lsu_err,
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rdata,
    input  mem_en, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates LSU and instruction-fetch access to one synchronous-read word RAM,
// with byte/half lane steering, load extension and misalignment rejection.
module dmem_port_arbiter #(
  parameter int BIN_DIG      = 32,
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  dmem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  logic [1:0]         state;
  logic [3:0]         starve;
  logic               own_if;
  logic               c_we;
  logic               c_uns;
  logic               c_err;
  logic [1:0]         c_size;
  logic [ADDR_W+1:0]  c_addr;
  logic [BIN_DIG-1:0] c_wdata;

  logic               grant_if;
  logic               grant_lsu;
  logic               misalign;
  logic [BIN_DIG-1:0] lane;
  logic [BIN_DIG-1:0] ext;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{bus.lsu_addr[BIN_DIG-1:ADDR_W+2],
                              bus.if_addr[BIN_DIG-1:ADDR_W+2], bus.if_addr[1:0]};

  // Grants are only offered in IDLE and are held off while reset is asserted.
  always_comb begin
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    if (state == IDLE && !rst) begin
      grant_if  = bus.if_req_valid && (!bus.lsu_req_valid || starve == LIMIT);
      grant_lsu = bus.lsu_req_valid && !grant_if;
    end
  end

  assign bus.lsu_req_ready = grant_lsu;
  assign bus.if_req_ready  = grant_if;

  always_comb begin
    case (bus.lsu_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = bus.lsu_addr[0];
      2'd2:    misalign = |bus.lsu_addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      starve  <= '0;
      own_if  <= 1'b0;
      c_we    <= 1'b0;
      c_uns   <= 1'b0;
      c_err   <= 1'b0;
      c_size  <= '0;
      c_addr  <= '0;
      c_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if) begin
            own_if  <= 1'b1;
            c_we    <= 1'b0;
            c_uns   <= 1'b0;
            c_err   <= 1'b0;
            c_size  <= 2'd2;
            c_addr  <= {bus.if_addr[ADDR_W+1:2], 2'b00};
            c_wdata <= '0;
            starve  <= '0;
            state   <= ACCESS;
          end else if (grant_lsu) begin
            own_if  <= 1'b0;
            c_we    <= bus.lsu_we;
            c_uns   <= bus.lsu_unsigned;
            c_err   <= misalign;
            c_size  <= bus.lsu_size;
            c_addr  <= bus.lsu_addr[ADDR_W+1:0];
            c_wdata <= bus.lsu_wdata;
            state   <= misalign ? RESP : ACCESS;
            if (!bus.if_req_valid)  starve <= '0;
            else if (starve < LIMIT) starve <= starve + 4'd1;
          end else if (!bus.if_req_valid) begin
            starve <= '0;
          end
        end
        ACCESS:  state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    lane = bus.mem_rdata >> {c_addr[1:0], 3'b000};
    case (c_size)
      2'd0:    ext = {{(BIN_DIG-8){~c_uns & lane[7]}}, lane[7:0]};
      2'd1:    ext = {{(BIN_DIG-16){~c_uns & lane[15]}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    bus.mem_en        = 1'b0;
    bus.mem_be        = '0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.lsu_rsp_valid = 1'b0;
    bus.lsu_rdata     = '0;
    bus.lsu_err       = 1'b0;
    bus.if_rsp_valid  = 1'b0;
    bus.if_rdata      = '0;
    if (state == ACCESS) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = c_addr[ADDR_W+1:2];
      if (c_we) begin
        case (c_size)
          2'd0: begin
            bus.mem_be    = 4'b0001 << c_addr[1:0];
            bus.mem_wdata = {4{c_wdata[7:0]}};
          end
          2'd1: begin
            bus.mem_be    = 4'b0011 << {c_addr[1], 1'b0};
            bus.mem_wdata = {2{c_wdata[15:0]}};
          end
          default: begin
            bus.mem_be    = 4'b1111;
            bus.mem_wdata = c_wdata;
          end
        endcase
      end
    end else if (state == RESP) begin
      if (own_if) begin
        bus.if_rsp_valid = 1'b1;
        bus.if_rdata     = bus.mem_rdata;
      end else begin
        bus.lsu_rsp_valid = 1'b1;
        bus.lsu_err       = c_err;
        if (!c_we && !c_err) bus.lsu_rdata = ext;
      end
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised and directed bench for dmem_port_arbiter against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
  localparam int BIN_DIG      = 32;
  localparam int ADDR_W       = 10;
  localparam int STARVE_LIMIT = 4;
  localparam int DEPTH        = 1 << ADDR_W;
  localparam int NBYTES       = 4 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fill = 1'b1;
  int unsigned en_count = 0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.BIN_DIG(BIN_DIG), .ADDR_W(ADDR_W)) bus ();

  dmem_port_arbiter #(.BIN_DIG(BIN_DIG), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Bench-side word RAM with synchronous read.
  logic [31:0] ram [DEPTH];

  function automatic logic [31:0] seed_word(int unsigned i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= seed_word(i);
      bus.mem_rdata <= '0;
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  always @(posedge clk) if (bus.mem_en === 1'b1) en_count <= en_count + 1;

  // Reference model: flat little-endian byte memory.
  logic [7:0] refb [NBYTES];

  function automatic bit model_misaligned(logic [31:0] a, int size);
    return (size == 3) || (size == 1 && (a % 2) != 0) || (size == 2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, int size, bit uns);
    int unsigned base = a % NBYTES;
    int n = 1 << size;
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(refb[(base + k) % NBYTES]) << (8 * k));
    if (size == 0 && !uns && v[7])  v = v | 32'hFFFFFF00;
    if (size == 1 && !uns && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  function automatic logic [31:0] model_word(logic [31:0] a);
    return model_load(a & 32'hFFFFFFFC, 2, 1'b1);
  endfunction

  task automatic model_store(logic [31:0] a, int size, logic [31:0] wd);
    int unsigned base = a % NBYTES;
    for (int k = 0; k < (1 << size); k++) refb[(base + k) % NBYTES] = 8'(wd >> (8 * k));
  endtask

  task automatic model_init();
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = seed_word(i);
      for (int b = 0; b < 4; b++) refb[4*i + b] = 8'(w >> (8 * b));
    end
  endtask

  // Drives one LSU request and reports what the DUT did; callers do the checking.
  task automatic lsu_op(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int ens, output logic [3:0] be,
                        output logic [ADDR_W-1:0] maddr, output logic [31:0] mwdata);
    int unsigned en0;
    int cyc;
    rdata = 'x; err = 1'bx; lat = -1; ens = -1; be = '0; maddr = '0; mwdata = '0;
    @(negedge clk);
    bus.lsu_req_valid = 1'b1; bus.lsu_we = we; bus.lsu_size = size;
    bus.lsu_unsigned = uns; bus.lsu_addr = addr; bus.lsu_wdata = wdata;
    #1;
    cyc = 0;
    while (bus.lsu_req_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    if (bus.lsu_req_ready !== 1'b1) begin bus.lsu_req_valid = 1'b0; return; end
    en0 = en_count;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.lsu_req_valid = 1'b0;
      if (bus.mem_en === 1'b1) begin be = bus.mem_be; maddr = bus.mem_addr; mwdata = bus.mem_wdata; end
      if (bus.lsu_rsp_valid === 1'b1) begin
        lat = c; rdata = bus.lsu_rdata; err = bus.lsu_err;
        break;
      end
    end
    ens = int'(en_count - en0);
  endtask

  task automatic if_op(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
    int cyc;
    rdata = 'x; lat = -1;
    @(negedge clk);
    bus.if_req_valid = 1'b1; bus.if_addr = addr;
    #1;
    cyc = 0;
    while (bus.if_req_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    if (bus.if_req_ready !== 1'b1) begin bus.if_req_valid = 1'b0; return; end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.if_req_valid = 1'b0;
      if (bus.if_rsp_valid === 1'b1) begin lat = c; rdata = bus.if_rdata; break; end
    end
  endtask

  function automatic logic [115:0] all_outputs();
    return {bus.lsu_req_ready, bus.lsu_rsp_valid, bus.lsu_rdata, bus.lsu_err,
            bus.if_req_ready, bus.if_rsp_valid, bus.if_rdata,
            bus.mem_en, bus.mem_be, bus.mem_addr, bus.mem_wdata};
  endfunction

  logic [31:0] rd;
  logic        er;
  int          lat, ens;
  logic [3:0]  be;
  logic [ADDR_W-1:0] ma;
  logic [31:0] mw;

  task automatic test_reset();
    model_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    fill = 1'b0;
    bus.lsu_req_valid = 1'b1; bus.if_req_valid = 1'b1;
    #1;
    vectors++; if (all_outputs() !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", all_outputs()); end
    @(negedge clk);
    rst = 1'b0;
    bus.lsu_req_valid = 1'b0; bus.if_req_valid = 1'b0;
    #1;
    vectors++; if (all_outputs() !== '0) begin miscompares++; $display("FAIL idle_outputs: got %h want 0", all_outputs()); end
  endtask

  task automatic test_store_word();
    lsu_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, ens, be, ma, mw);
    model_store(32'h10, 2, 32'hDEADBEEF);
    vectors++; if (be !== 4'b1111) begin miscompares++; $display("FAIL sw_be: got %b want 1111", be); end
    vectors++; if (ma !== 10'd4) begin miscompares++; $display("FAIL sw_addr: got %0d want 4", ma); end
    vectors++; if (mw !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_wdata: got %h want deadbeef", mw); end
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sw_latency: got %0d want 2", lat); end
    vectors++; if ({er, rd} !== 33'h0) begin miscompares++; $display("FAIL sw_rsp: got err %b rdata %h want 0/0", er, rd); end
    vectors++; if (ens !== 1) begin miscompares++; $display("FAIL sw_en_count: got %0d want 1", ens); end
  endtask

  task automatic test_byte();
    lsu_op(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, rd, er, lat, ens, be, ma, mw);
    model_store(32'h13, 0, 32'hA5);
    vectors++; if (be !== 4'b1000) begin miscompares++; $display("FAIL sb_be: got %b want 1000", be); end
    vectors++; if (mw !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL sb_wdata: got %h want a5a5a5a5", mw); end
    lsu_op(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er, lat, ens, be, ma, mw);
    vectors++; if (rd !== 32'hFFFFFFA5) begin miscompares++; $display("FAIL lb: got %h want ffffffa5", rd); end
    vectors++; if (be !== 4'b0000) begin miscompares++; $display("FAIL lb_be: got %b want 0000", be); end
    lsu_op(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er, lat, ens, be, ma, mw);
    vectors++; if (rd !== 32'h000000A5) begin miscompares++; $display("FAIL lbu: got %h want 000000a5", rd); end
    lsu_op(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, rd, er, lat, ens, be, ma, mw);
    vectors++; if (rd !== model_load(32'h10, 0, 1'b0)) begin miscompares++; $display("FAIL lb_lane0: got %h want %h", rd, model_load(32'h10, 0, 1'b0)); end
  endtask

  task automatic test_half();
    lsu_op(1'b1, 2'd1, 1'b0, 32'h12, 32'h12348001, rd, er, lat, ens, be, ma, mw);
    model_store(32'h12, 1, 32'h8001);
    vectors++; if (be !== 4'b1100) begin miscompares++; $display("FAIL sh_be: got %b want 1100", be); end
    vectors++; if (mw !== 32'h80018001) begin miscompares++; $display("FAIL sh_wdata: got %h want 80018001", mw); end
    lsu_op(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er, lat, ens, be, ma, mw);
    vectors++; if (rd !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh: got %h want ffff8001", rd); end
    lsu_op(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er, lat, ens, be, ma, mw);
    vectors++; if (rd !== 32'h00008001) begin miscompares++; $display("FAIL lhu: got %h want 00008001", rd); end
    lsu_op(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, rd, er, lat, ens, be, ma, mw);
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL lh_mis_err: got %b want 1", er); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL lh_mis_latency: got %0d want 1", lat); end
    vectors++; if (ens !== 0) begin miscompares++; $display("FAIL lh_mis_mem_en: got %0d want 0", ens); end
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL lh_mis_rdata: got %h want 0", rd); end
    lsu_op(1'b1, 2'd3, 1'b0, 32'h20, 32'h55555555, rd, er, lat, ens, be, ma, mw);
    vectors++; if ({er, ens} !== {1'b1, 32'd0}) begin miscompares++; $display("FAIL size3_err: got err %b ens %0d want 1/0", er, ens); end
  endtask

  task automatic test_starvation();
    int consec = 0, grants = 0, cyc = 0, if_rsps = 0;
    bit exp_if;
    logic [31:0] if_q [$];
    logic [31:0] a;
    @(negedge clk);
    bus.lsu_req_valid = 1'b1; bus.lsu_we = 1'b0; bus.lsu_size = 2'd2;
    bus.lsu_unsigned = 1'b0; bus.lsu_addr = 32'h40; bus.lsu_wdata = '0;
    bus.if_req_valid = 1'b1; bus.if_addr = {22'($urandom), 10'($urandom)} & 32'h3FC;
    #1;
    while ((grants < 10 || cyc < 40) && cyc < 200) begin
      if (bus.if_rsp_valid === 1'b1) begin
        a = (if_q.size() != 0) ? if_q.pop_front() : 32'hx;
        if_rsps++;
        vectors++; if (bus.if_rdata !== model_word(a)) begin miscompares++; $display("FAIL starve_if_rdata: got %h want %h", bus.if_rdata, model_word(a)); end
      end
      if (bus.lsu_rsp_valid === 1'b1) begin
        vectors++; if (bus.lsu_rdata !== model_load(32'h40, 2, 1'b0)) begin miscompares++; $display("FAIL starve_lsu_rdata: got %h want %h", bus.lsu_rdata, model_load(32'h40, 2, 1'b0)); end
      end
      if (grants < 10 && (bus.lsu_req_ready === 1'b1 || bus.if_req_ready === 1'b1)) begin
        exp_if = (consec == STARVE_LIMIT);
        vectors++; if ({bus.if_req_ready, bus.lsu_req_ready} !== {exp_if, !exp_if}) begin miscompares++; $display("FAIL starve_grant%0d: got if/lsu %b%b want %b%b", grants, bus.if_req_ready, bus.lsu_req_ready, exp_if, !exp_if); end
        if (bus.if_req_ready === 1'b1) begin
          if_q.push_back(bus.if_addr);
          consec = 0;
        end else consec++;
        grants++;
      end
      @(negedge clk);
      cyc++;
      if (if_q.size() != 0 && bus.if_req_ready !== 1'b1) bus.if_addr = $urandom & 32'h3FC;
      if (grants >= 10) begin bus.lsu_req_valid = 1'b0; bus.if_req_valid = 1'b0; end
    end
    vectors++; if (grants !== 10) begin miscompares++; $display("FAIL starve_grant_count: got %0d want 10", grants); end
    vectors++; if (if_rsps !== 2) begin miscompares++; $display("FAIL starve_if_rsps: got %0d want 2", if_rsps); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    bit saw = 1'b0;
    @(negedge clk);
    bus.lsu_req_valid = 1'b1; bus.lsu_we = 1'b1; bus.lsu_size = 2'd2;
    bus.lsu_unsigned = 1'b0; bus.lsu_addr = 32'h20; bus.lsu_wdata = 32'hCAFEF00D;
    #1;
    while (bus.lsu_req_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    bus.lsu_req_valid = 1'b0;
    vectors++; if (bus.mem_en !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_access: got mem_en %b want 1", bus.mem_en); end
    rst = 1'b1;
    #1;
    vectors++; if (all_outputs() !== '0) begin miscompares++; $display("FAIL rstmid_outputs: got %h want 0", all_outputs()); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.lsu_rsp_valid !== 1'b0 || bus.mem_en !== 1'b0) saw = 1'b1;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.lsu_rsp_valid !== 1'b0 || bus.mem_en !== 1'b0) saw = 1'b1;
    end
    vectors++; if (saw !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_activity: got 1 want 0"); end
    lsu_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, ens, be, ma, mw);
    vectors++; if (rd !== model_load(32'h20, 2, 1'b0)) begin miscompares++; $display("FAIL rstmid_store_aborted: got %h want %h", rd, model_load(32'h20, 2, 1'b0)); end
    lsu_op(1'b1, 2'd2, 1'b0, 32'h20, 32'h13572468, rd, er, lat, ens, be, ma, mw);
    model_store(32'h20, 2, 32'h13572468);
    vectors++; if ({lat, er} !== {32'd2, 1'b0}) begin miscompares++; $display("FAIL rstmid_recover: got lat %0d err %b want 2/0", lat, er); end
  endtask

  task automatic test_wrap();
    logic [31:0] w = $urandom;
    lsu_op(1'b1, 2'd2, 1'b0, 32'h1008, w, rd, er, lat, ens, be, ma, mw);
    model_store(32'h1008, 2, w);
    vectors++; if (ma !== 10'd2) begin miscompares++; $display("FAIL wrap_addr: got %0d want 2", ma); end
    lsu_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, er, lat, ens, be, ma, mw);
    vectors++; if (rd !== w) begin miscompares++; $display("FAIL wrap_readback: got %h want %h", rd, w); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd, exp_rd;
    logic [1:0] sz;
    bit we, uns, mis;
    logic [3:0] exp_be;
    for (int i = 0; i < 80; i++) begin
      a = ($urandom & 32'hFFFFF000) | $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) begin
        if_op(a, rd, lat);
        vectors++; if ({lat, rd} !== {32'd2, model_word(a)}) begin miscompares++; $display("FAIL rand_if%0d: got lat %0d rdata %h want 2 %h", i, lat, rd, model_word(a)); end
      end else begin
        we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom); wd = $urandom;
        if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
        mis = model_misaligned(a, int'(sz));
        exp_rd = (we || mis) ? 32'h0 : model_load(a, int'(sz), uns);
        exp_be = (we && !mis) ? 4'(((1 << (1 << sz)) - 1) << (a % 4)) : 4'b0000;
        lsu_op(we, sz, uns, a, wd, rd, er, lat, ens, be, ma, mw);
        if (we && !mis) model_store(a, int'(sz), wd);
        vectors++; if ({rd, er, lat, ens, be} !== {exp_rd, mis, mis ? 32'd1 : 32'd2, mis ? 32'd0 : 32'd1, exp_be}) begin
          miscompares++;
          $display("FAIL rand_lsu%0d: got rdata %h err %b lat %0d ens %0d be %b want %h %b %0d %0d %b", i, rd, er, lat, ens, be, exp_rd, mis, mis ? 1 : 2, mis ? 0 : 1, exp_be);
        end
      end
    end
  endtask

  initial begin
    bus.lsu_req_valid = 1'b0; bus.lsu_we = 1'b0; bus.lsu_size = '0; bus.lsu_unsigned = 1'b0;
    bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.if_req_valid = 1'b0; bus.if_addr = '0;
    test_reset();
    test_store_word();
    test_byte();
    test_half();
    test_starvation();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied", vectors);
    $fatal(1);
  end
endmodule
